// File: rtl/return_addr_stack.sv
// Hardware return-address stack fed by CALL (push) / RET (pop) strobes, sampled in one pipeline stage.
// Optional build macro RSTACK_WRAP_EN: a push into a full stack overwrites the oldest entry.
module return_addr_stack #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PTR_W     = 4,
    parameter logic [2:0]  ACT_STAGE = 3'b011
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [2:0]        stage_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              err_clr_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              pop_valid_o,
    output logic [DATA_W-1:0] top_o,
    output logic [PTR_W:0]    count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    // Handshake: push_i/pop_i are level requests honoured on every cycle where
    // stage_i == ACT_STAGE; there is no backpressure. pop_valid_o pulses for one
    // cycle after each honoured pop (underflow included) and pop_data_o holds its
    // value until the next honoured pop.

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [PTR_W-1:0]  sp_m1;
    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              act;
    logic              push_ok;
    logic              pop_ok;
    logic              is_empty;
    logic              is_full;

    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;

    assign act      = (stage_i == ACT_STAGE);
    assign push_ok  = push_i & act;
    assign pop_ok   = pop_i & act;
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);
    assign sp_m1    = sp_q - PTR_W'(1);

    always_comb begin
        sp_d        = sp_q;
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = pop_ok;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = sp_q;

        // Clear first so that an error raised in the same cycle wins.
        if (err_clr_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        if (push_ok && pop_ok) begin
            if (!is_empty) begin
                pop_data_d = mem_q[sp_m1];
                mem_we     = 1'b1;
                mem_waddr  = sp_m1;
            end else begin
                underflow_d = 1'b1;
                pop_data_d  = '0;
                mem_we      = 1'b1;
                mem_waddr   = sp_q;
                sp_d        = sp_q + PTR_W'(1);
                count_d     = count_q + (PTR_W+1)'(1);
            end
        end else if (pop_ok) begin
            if (!is_empty) begin
                pop_data_d = mem_q[sp_m1];
                sp_d       = sp_m1;
                count_d    = count_q - (PTR_W+1)'(1);
            end else begin
                pop_data_d  = '0;
                underflow_d = 1'b1;
            end
        end else if (push_ok) begin
            if (!is_full) begin
                mem_we    = 1'b1;
                mem_waddr = sp_q;
                sp_d      = sp_q + PTR_W'(1);
                count_d   = count_q + (PTR_W+1)'(1);
            end else begin
                overflow_d = 1'b1;
`ifdef RSTACK_WRAP_EN
                // When full, sp has wrapped onto the oldest entry.
                mem_we    = 1'b1;
                mem_waddr = sp_q;
                sp_d      = sp_q + PTR_W'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q        <= '0;
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (mem_we && rst_ni) begin
            mem_q[mem_waddr] <= push_data_i;
        end
    end

    assign pop_data_o  = pop_data_q;
    assign pop_valid_o = pop_valid_q;
    assign top_o       = is_empty ? '0 : mem_q[sp_m1];
    assign count_o     = count_q;
    assign empty_o     = is_empty;
    assign full_o      = is_full;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule
